csub_36bit_serial: RTL

Multi-cycle 36-bit subtractor, the inverse-direction companion to the combinational carry-lookahead adder. It computes minuend − subtrahend one 9-bit chunk per clock, with a registered carry between chunks, and returns the 36-bit difference plus a borrow flag. It sits behind a valid/ready handshake on both sides so that arithmetic datapaths can trade latency for a short carry chain.

---
 rtl/csub_pkg.sv | 27 ++
 rtl/cla_chunk.sv | 54 +++++
 rtl/full_adder.sv | 21 ++
 rtl/csub_36bit_serial.sv | 119 +++++++++++
 4 files changed

// File: rtl/csub_pkg.sv
// Shared definitions for the serial chunked subtractor.
//   state_t    : FSM encoding (IDLE / RUN / DONE)
//   DEF_WIDTH  : default operand width
//   DEF_CHUNK  : default bits handled per clock
//   num_chunks : chunk count for a given width/chunk pair
//   idx_width  : width of the chunk index counter (never below 1)
package csub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 36;
  localparam int DEF_CHUNK = 9;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational N-bit carry-lookahead adder with carry in and carry out.
//   a, b : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the top bit
module cla_chunk
  import csub_pkg::*;
#(
  parameter int N = DEF_CHUNK
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .g   (g[i]),
      .p   (p[i])
    );
  end

  // Each carry is a flat sum of products over g/p/cin:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  // so no carry depends on another carry.
  always_comb begin
    logic pp;
    c  = '0;
    pp = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end

  assign cout = c[N];

endmodule

// File: rtl/full_adder.sv
// One-bit adder cell exposing generate/propagate so a lookahead network
// can form carries without rippling through the cells.
//   a, b : addend bits
//   cin  : carry into this bit
//   sum  : sum bit
//   g    : generate (a & b)
//   p    : propagate (a ^ b)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic g,
  output logic p
);

  assign p   = a ^ b;
  assign g   = a & b;
  assign sum = p ^ cin;

endmodule

// File: rtl/csub_36bit_serial.sv
// Multi-cycle subtractor: o_result = {borrow, i_min - i_sub}, one CHUNK-bit
// slice per clock through a single shared lookahead adder.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_valid      : operands presented     o_ready : operands accepted in IDLE
//   i_min, i_sub : minuend, subtrahend
//   o_valid      : result available       i_ready : downstream takes result
//   o_result     : {borrow, difference}; borrow=1 when i_min < i_sub
//   dbg_state    : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid holds with its data until that edge. o_ready/o_valid are
// registers, so neither depends combinationally on i_valid/i_ready.
// WIDTH must be an integer multiple of CHUNK.
module csub_36bit_serial
  import csub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output state_t           dbg_state
);

  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;      // captured minuend
  logic [WIDTH-1:0] b_q;      // captured, inverted subtrahend
  logic [WIDTH:0]   res_q;    // {borrow, difference}
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;
  logic             valid_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic             c_out;

  // Select the active slice for the shared adder.
  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  cla_chunk #(.N(CHUNK)) u_cla (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (d_chunk),
    .cout (c_out)
  );

  // A - B = A + ~B + 1: carry starts at 1 and the final carry out is
  // the inverse of the borrow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b1;
      idx_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_min;
            b_q     <= ~i_sub;
            res_q   <= '0;
            carry_q <= 1'b1;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q[idx_q*CHUNK +: CHUNK] <= d_chunk;
          carry_q <= c_out;
          if (idx_q == LAST_IDX) begin
            res_q[WIDTH] <= ~c_out;
            idx_q        <= '0;
            valid_q      <= 1'b1;
            state        <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_result  = res_q;
  assign dbg_state = state;

endmodule
